// File: rtl/unpack.sv
// Wide-to-narrow stream converter: one W*D-bit word in, D W-bit beats out, lane 0 first.
// Optional UNPACK_LEN_EN adds s_len, the final lane index of each word (s_len+1 beats).
module unpack #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_stb,
  input  logic [W*D-1:0]         s_dat,
`ifdef UNPACK_LEN_EN
  input  logic [$clog2(D)-1:0]   s_len,
`endif
  output logic                   s_rdy,
  input  logic                   m_rdy,
  output logic                   m_stb,
  output logic [W-1:0]           m_dat,
  output logic                   m_last
);

  localparam int IW = $clog2(D);

  // Handshake: a word moves on s_stb & s_rdy, a beat moves on m_stb & m_rdy;
  // m_stb/m_dat/m_last are never changed while m_stb & ~m_rdy.

  // Lane 0 goes straight to m_dat on load, so only lanes 1..D-1 are held.
  logic [W*(D-1)-1:0] rest_q;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      nxt_idx;
  logic [IW-1:0]      last_idx;
  logic [IW-1:0]      load_last;
  logic               load;
  logic               adv;
  logic               drain;

  assign s_rdy   = ~m_stb | (m_rdy & m_last);
  assign load    = s_stb & s_rdy;
  assign adv     = m_stb & m_rdy & ~m_last;
  assign drain   = m_stb & m_rdy & m_last;
  assign nxt_idx = idx + 1'b1;

`ifdef UNPACK_LEN_EN
  logic [IW-1:0] end_q;

  always_ff @(posedge clk) begin
    if (load) end_q <= s_len;
  end

  assign load_last = s_len;
  assign last_idx  = end_q;
`else
  assign load_last = IW'(D - 1);
  assign last_idx  = IW'(D - 1);
`endif

  always_ff @(posedge clk) begin
    if (load) rest_q <= s_dat[W*D-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_stb  <= 1'b0;
      m_last <= 1'b0;
      m_dat  <= '0;
      idx    <= '0;
    end else if (load) begin
      idx    <= '0;
      m_dat  <= s_dat[W-1:0];
      m_stb  <= 1'b1;
      m_last <= (load_last == '0);
    end else if (adv) begin
      // rest_q lane idx is the word's lane idx+1.
      idx    <= nxt_idx;
      m_dat  <= rest_q[W*int'(idx) +: W];
      m_last <= (nxt_idx == last_idx);
    end else if (drain) begin
      m_stb  <= 1'b0;
      m_last <= 1'b0;
    end
  end

endmodule

// File: doc/unpack.md
Name: unpack

Overview:
- Wide-to-narrow stream converter: accepts one W*D-bit word per handshake and emits it as D consecutive W-bit beats.
- Lane 0 (bits W-1:0) is emitted first. This is the inverse of the narrow-to-wide packer, so a packer followed by unpack is an identity.
- Sits between wide datapath stages (e.g. vector results) and narrow consumers (serial links, byte-wide memories).
- Uses the same stb/rdy valid-ready handshake as the rest of the datapath.

Parameters:
- W, 8, width in bits of one output beat (lane); W >= 1.
- D, 2, number of lanes per input word; D >= 2. Lane index width is $clog2(D).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-low (asserted when 0).
- s_stb  input  1  input word valid.
- s_dat  input  W*D  input word; lane k = s_dat[W*k+:W].
- s_rdy  output  1  input ready; word transferred when s_stb & s_rdy.
- m_rdy  input  1  output ready; beat transferred when m_stb & m_rdy.
- m_stb  output  1  output beat valid (registered).
- m_dat  output  W  output beat data (registered).
- m_last  output  1  high with the final beat of each word (registered).

Behaviour:
- State:
  - buf: W*D holding register.
  - idx: current lane index.
  - end: index of the final lane, D-1, or s_len with the optional feature.
  - m_stb, m_dat, m_last.
- Reset (rst==0 at a clock edge): m_stb=0, m_last=0, m_dat=0, idx=0. Reset wins over any simultaneous handshake. An in-flight word is discarded; no partial beats resume after reset.
- s_rdy = ~m_stb | (m_rdy & m_last). This is combinational from m_rdy and allows zero-bubble back-to-back words. s_rdy is high during reset.
- Load (s_stb & s_rdy):
  - buf <= s_dat, idx <= 0.
  - m_dat <= s_dat[W-1:0], m_stb <= 1, m_last <= (end==0).
  - Latency: first beat valid the cycle after acceptance.
- Advance (m_stb & m_rdy & ~m_last):
  - idx <= idx+1.
  - m_dat <= buf[W*(idx+1)+:W].
  - m_last <= (idx+1 == end).
- Drain (m_stb & m_rdy & m_last with no load in the same cycle): m_stb <= 0, m_last <= 0. m_dat holds its last value.
- Simultaneous drain and load (m_rdy & m_last & s_stb): load wins; the new word's lane 0 appears next cycle with m_stb still 1.
- Stall (m_stb & ~m_rdy): m_dat, m_last, m_stb and idx held stable. AXI-style: a valid beat is never withdrawn.
- Throughput: D beats per word at full rate; one word per D cycles when m_rdy is held high.
- idx never exceeds end, so there is no wrap-around beyond D-1. For non-power-of-two D, unused idx codes are unreachable.
- s_dat is sampled only on the accepting edge; changes at other times are ignored.

Optional Feature:
- Macro: UNPACK_LEN_EN.
- Defined:
  - Adds input port s_len, width $clog2(D), sampled with s_dat on load. It gives the final lane index, so s_len+1 beats are emitted.
  - end <= s_len on load; lanes above s_len are never emitted. s_len==0 yields a single beat with m_last=1.
- Undefined: no s_len port; end is constant D-1; every word emits exactly D beats.

Test Plan:
- Basic (W=8, D=2): s_dat=16'hBEEF with m_rdy=1 -> next cycle m_dat=8'hEF, m_last=0; following cycle m_dat=8'hBE, m_last=1; then m_stb=0.
- Back-to-back (W=8, D=2): s_stb held high with 16'h1122 then 16'h3344, m_rdy=1 -> beats 22,11,44,33 on 4 consecutive cycles, m_stb never drops, s_rdy high on the m_last cycles.
- Backpressure (W=8, D=4): load 32'hDDCCBBAA, m_rdy low 3 cycles after first beat -> m_dat stays 8'hAA, s_rdy=0 throughout; then beats BB,CC,DD follow in order, m_last only on DD.
- Reset mid-word (W=8, D=4): drive rst=0 after the 2nd beat -> next cycle m_stb=0, m_last=0, m_dat=0, s_rdy=1; a new word 32'h04030201 then emits 01,02,03,04 from lane 0.
- UNPACK_LEN_EN (W=8, D=4): s_dat=32'h44332211 with s_len=1 -> beats 11,22 only, m_last on 22. Next word with s_len=0 -> single beat with m_last=1.
- Randomized stb/rdy against a packer: random s_stb/m_rdy over 1000 words, unpack output fed to the packer -> output words equal input words in order, no drops or duplicates.
